// File: rtl/psec5_spi_pkg.sv
// Shared definitions for the SPI command receiver: FSM states and address-map constants.
package psec5_spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        READ = 2'd3
    } state_t;

    localparam int unsigned NUM_REGS_DEFAULT = 59;
    localparam logic [6:0]  RESERVED_ADDR    = 7'd0;
    localparam int unsigned WRITE_FLAG_BIT   = 7;

endpackage

// File: rtl/s2p_shift_register.sv
// 8-bit LSB-first serial-to-parallel shifter with a wrapping bit counter.
module s2p_shift_register (
    input  logic       sclk,
    input  logic       rstn,
    input  logic       clear,
    input  logic       shift_en,
    input  logic       serial_in,
    output logic [7:0] next_byte,
    output logic       byte_done
);

    logic [7:0] shreg;
    logic [2:0] bit_cnt;

    // Byte value including the bit sampled on this edge, so the FSM can decode on the completing edge.
    assign next_byte = {serial_in, shreg[7:1]};
    assign byte_done = shift_en && (bit_cnt == 3'd7);

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            shreg   <= next_byte;
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/spi_cmd_receiver.sv
// SPI command receiver: decodes an LSB-first command byte, then either captures a write
// payload or selects a register for an 8-cycle readback through the downstream shifter.
module spi_cmd_receiver
    import psec5_spi_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT
) (
    input  logic       sclk,
    input  logic       rstn,
    input  logic       csn,
    input  logic       serial_in,
    output logic [7:0] mux_addr,
    output logic       p2s_rstn,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       addr_err,
    output logic       busy
);

    localparam logic [7:0] MAX_ADDR = 8'(NUM_REGS);

    state_t     state, state_next;
    logic [2:0] read_cnt, read_cnt_next;
    logic [6:0] cmd_addr, cmd_addr_next;
    logic [7:0] mux_addr_next, wr_addr_next, wr_data_next;
    logic       wr_en_next, addr_err_next;

    logic [7:0] rx_byte;
    logic [7:0] rx_addr;
    logic       byte_done;
    logic       shift_en;

    // Shifting is active in IDLE too so the first command bit is captured on the frame-start edge.
    assign shift_en = !csn && (state != READ);
    assign rx_addr  = {1'b0, rx_byte[6:0]};
    assign busy     = (state != IDLE);

    s2p_shift_register u_s2p (
        .sclk      (sclk),
        .rstn      (rstn),
        .clear     (csn),
        .shift_en  (shift_en),
        .serial_in (serial_in),
        .next_byte (rx_byte),
        .byte_done (byte_done)
    );

    always_comb begin
        state_next    = state;
        read_cnt_next = read_cnt;
        cmd_addr_next = cmd_addr;
        mux_addr_next = mux_addr;
        wr_addr_next  = wr_addr;
        wr_data_next  = wr_data;
        wr_en_next    = 1'b0;
        addr_err_next = 1'b0;

        unique case (state)
            IDLE: begin
                if (!csn) state_next = ADDR;
            end
            ADDR: begin
                if (csn) begin
                    state_next = IDLE;
                end else if (byte_done) begin
                    if (rx_byte[WRITE_FLAG_BIT]) begin
                        state_next    = DATA;
                        cmd_addr_next = rx_byte[6:0];
                    end else begin
                        state_next    = READ;
                        read_cnt_next = '0;
                        if (rx_addr > MAX_ADDR) begin
                            mux_addr_next = '0;
                            addr_err_next = 1'b1;
                        end else begin
                            mux_addr_next = rx_addr;
                        end
                    end
                end
            end
            DATA: begin
                if (csn) begin
                    state_next = IDLE;
                end else if (byte_done) begin
                    state_next = ADDR;
                    if ((cmd_addr != RESERVED_ADDR) && ({1'b0, cmd_addr} <= MAX_ADDR)) begin
                        wr_en_next   = 1'b1;
                        wr_addr_next = {1'b0, cmd_addr};
                        wr_data_next = rx_byte;
                    end else begin
                        addr_err_next = 1'b1;
                    end
                end
            end
            READ: begin
                if (csn) begin
                    state_next = IDLE;
                end else if (read_cnt == 3'd7) begin
                    state_next = ADDR;
                end else begin
                    read_cnt_next = read_cnt + 3'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            read_cnt <= '0;
            cmd_addr <= '0;
            mux_addr <= '0;
            p2s_rstn <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_next;
            read_cnt <= read_cnt_next;
            cmd_addr <= cmd_addr_next;
            mux_addr <= mux_addr_next;
            p2s_rstn <= (state_next == READ);
            wr_en    <= wr_en_next;
            wr_addr  <= wr_addr_next;
            wr_data  <= wr_data_next;
            addr_err <= addr_err_next;
        end
    end

endmodule

// File: tb/tb_spi_cmd_receiver.sv
// Directed self-checking bench for spi_cmd_receiver with hand-computed expectations.
module tb_spi_cmd_receiver;

    logic       sclk;
    logic       rstn;
    logic       csn;
    logic       serial_in;
    logic [7:0] mux_addr;
    logic       p2s_rstn;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       addr_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int n_wr, n_err, n_p2s, n_idle;

    spi_cmd_receiver #(.NUM_REGS(59)) dut (
        .sclk      (sclk),
        .rstn      (rstn),
        .csn       (csn),
        .serial_in (serial_in),
        .mux_addr  (mux_addr),
        .p2s_rstn  (p2s_rstn),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .addr_err  (addr_err),
        .busy      (busy)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_wr = 0; n_err = 0; n_p2s = 0; n_idle = 0;
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic clk_bit(input logic cs, input logic b);
        @(negedge sclk);
        csn       = cs;
        serial_in = b;
        @(posedge sclk);
        #1;
        n_wr   += int'(wr_en);
        n_err  += int'(addr_err);
        n_p2s  += int'(p2s_rstn);
        n_idle += int'(!busy);
    endtask

    task automatic send_byte(input logic [7:0] val);
        for (int i = 0; i < 8; i++) clk_bit(1'b0, val[i]);
    endtask

    task automatic do_write(input string tag, input logic [7:0] cmd, input logic [7:0] dat,
                            input logic exp_en, input logic exp_err,
                            input logic [7:0] exp_addr, input logic [7:0] exp_data);
        clear_counts();
        send_byte(cmd);
        send_byte(dat);
        check({tag, "_wr_en"}, wr_en, exp_en);
        check({tag, "_addr_err"}, addr_err, exp_err);
        clk_bit(1'b1, 1'b0);
        check({tag, "_wr_addr"}, wr_addr, exp_addr);
        check({tag, "_wr_data"}, wr_data, exp_data);
        check({tag, "_wr_count"}, n_wr, exp_en ? 1 : 0);
        check({tag, "_err_count"}, n_err, exp_err ? 1 : 0);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        rstn = 1'b0; csn = 1'b1; serial_in = 1'b0;
        clear_counts();
        #12;
        check("rst_mux_addr", mux_addr, 0);
        check("rst_p2s_rstn", p2s_rstn, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_addr_err", addr_err, 0);
        check("rst_busy", busy, 0);
        rstn = 1'b1;

        // Writes: basic, top legal address, reserved address, out-of-range address.
        do_write("wr85", 8'h85, 8'hA5, 1'b1, 1'b0, 8'h05, 8'hA5);
        do_write("wr59", 8'hBB, 8'h3C, 1'b1, 1'b0, 8'h3B, 8'h3C);
        do_write("wr0",  8'h80, 8'h77, 1'b0, 1'b1, 8'h3B, 8'h3C);
        do_write("wr60", 8'hBC, 8'hFF, 1'b0, 1'b1, 8'h3B, 8'h3C);

        // Full read of address 59, ending with csn high on the exit edge.
        clear_counts();
        send_byte(8'h3B);
        check("rd59_mux_addr", mux_addr, 59);
        check("rd59_p2s_on", p2s_rstn, 1);
        check("rd59_addr_err", addr_err, 0);
        for (int i = 0; i < 7; i++) clk_bit(1'b0, 1'b0);
        check("rd59_busy_last", busy, 1);
        clk_bit(1'b1, 1'b0);
        check("rd59_p2s_count", n_p2s, 8);
        check("rd59_p2s_off", p2s_rstn, 0);
        check("rd59_idle", busy, 0);

        // Read of address 0 is legal.
        clear_counts();
        send_byte(8'h00);
        check("rd0_mux_addr", mux_addr, 0);
        check("rd0_addr_err", addr_err, 0);
        clk_bit(1'b1, 1'b0);
        check("rd0_err_count", n_err, 0);

        // Read of address 64 selects reg 0 and flags the error.
        clear_counts();
        send_byte(8'h02);
        clk_bit(1'b1, 1'b0);
        check("pre_rd64_mux", mux_addr, 2);
        send_byte(8'h40);
        check("rd64_mux_addr", mux_addr, 0);
        check("rd64_addr_err", addr_err, 1);
        check("rd64_p2s_on", p2s_rstn, 1);
        clk_bit(1'b1, 1'b0);
        check("rd64_err_pulse", addr_err, 0);
        check("rd64_p2s_abort", p2s_rstn, 0);

        // Abort after 12 bits of a write.
        clear_counts();
        send_byte(8'h85);
        for (int i = 0; i < 4; i++) clk_bit(1'b0, 1'b1);
        clk_bit(1'b1, 1'b1);
        check("abort_busy", busy, 0);
        check("abort_wr_count", n_wr, 0);
        check("abort_p2s", p2s_rstn, 0);
        // Fresh frame after abort must decode from bit 0; then abort mid-READ.
        send_byte(8'h03);
        check("post_abort_mux", mux_addr, 3);
        clk_bit(1'b0, 1'b0);
        clk_bit(1'b1, 1'b0);
        check("rd_abort_busy", busy, 0);
        check("rd_abort_p2s", p2s_rstn, 0);
        check("rd_abort_mux_held", mux_addr, 3);

        // Back-to-back write then read with csn held low.
        clear_counts();
        send_byte(8'h81);
        send_byte(8'h11);
        check("b2b_wr_en", wr_en, 1);
        check("b2b_wr_addr", wr_addr, 8'h01);
        check("b2b_wr_data", wr_data, 8'h11);
        send_byte(8'h01);
        check("b2b_mux_addr", mux_addr, 1);
        check("b2b_p2s", p2s_rstn, 1);
        check("b2b_wr_count", n_wr, 1);
        check("b2b_no_idle", n_idle, 0);

        // Asynchronous reset during READ cycle 4.
        for (int i = 0; i < 3; i++) clk_bit(1'b0, 1'b0);
        check("pre_rst_p2s", p2s_rstn, 1);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_mux_addr", mux_addr, 0);
        check("arst_p2s", p2s_rstn, 0);
        check("arst_wr_addr", wr_addr, 0);
        check("arst_wr_data", wr_data, 0);
        check("arst_busy", busy, 0);
        check("arst_wr_en", wr_en, 0);
        check("arst_addr_err", addr_err, 0);
        rstn = 1'b1;
        do_write("post_rst", 8'h85, 8'h22, 1'b1, 1'b0, 8'h05, 8'h22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_cmd_receiver.md
SPI_CMD_RECEIVER -- requirements
Module: spi_cmd_receiver

Interface
REQ-001 SHALL have parameter NUM_REGS, default 59, the highest valid register address (address 0 is reserved).
REQ-002 SHALL have port sclk  input  1  serial clock; all state updates on posedge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port csn  input  1  active-low frame select, sampled on posedge sclk.
REQ-005 SHALL have port serial_in  input  1  PICO data, LSB first.
REQ-006 SHALL have port mux_addr  output  8  read-select to the output register mux.
REQ-007 SHALL have port p2s_rstn  output  1  active-low hold for the downstream parallel-to-serial shifter.
REQ-008 SHALL have port wr_en  output  1  single-cycle register-write strobe.
REQ-009 SHALL have port wr_addr  output  8  write target address.
REQ-010 SHALL have port wr_data  output  8  write payload.
REQ-011 SHALL have port addr_err  output  1  single-cycle invalid-address pulse.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, ADDR, DATA and READ.
REQ-014 IDLE: on a posedge with csn=0, SHALL sample bit 0 of the command byte, set bit count to 1 and go to ADDR.
REQ-015 ADDR and DATA SHALL shift serial_in into an 8-bit LSB-first register: shreg <= {serial_in, shreg[7:1]}.
REQ-016 The 3-bit bit counter SHALL wrap 7->0; byte completion is the edge that samples the 8th bit.
REQ-017 On command-byte completion, bit 7 is the write flag and bits 6:0 are the address.
REQ-018 Command with flag=0 (read): mux_addr SHALL be set to {1'b0, addr[6:0]} on the completing edge, or to 0 if the address is greater than NUM_REGS; the state SHALL then go to READ.
REQ-019 p2s_rstn SHALL be registered: 1 exactly during the 8 READ cycles, 0 otherwise. The downstream shifter therefore emits mux_addr-selected data bits 0..7 on the 8 following edges.
REQ-020 After 8 READ cycles, the block SHALL go to ADDR if csn=0 (back-to-back command) or to IDLE if csn=1.
REQ-021 Command with flag=1 (write): the block SHALL go to DATA and hold the address internally.
REQ-022 On data-byte completion with address in 1..NUM_REGS: wr_en SHALL be 1 for exactly the next cycle, with wr_addr and wr_data valid in that same cycle; wr_addr/wr_data SHALL hold afterwards.
REQ-023 The next state after a write SHALL be ADDR if csn=0, else IDLE.
REQ-024 An address equal to 0 or greater than NUM_REGS on a write SHALL suppress wr_en and pulse addr_err for one cycle at data completion.
REQ-025 An address greater than NUM_REGS on a read SHALL pulse addr_err at command completion; READ proceeds and shifts reg 0 (zeros).
REQ-026 A read of address 0 is legal: no addr_err.
REQ-027 csn=1 sampled in ADDR, DATA or READ SHALL abort to IDLE on that edge:
- partial byte discarded;
- no wr_en;
- p2s_rstn forced 0;
- mux_addr held.
REQ-028 Latency: wr_en SHALL assert 1 cycle after the 16th bit edge; mux_addr SHALL be valid on the edge sampling the 8th command bit.

Reset
REQ-029 rstn=0 SHALL asynchronously force:
- state IDLE;
- counter 0;
- shreg 0;
- mux_addr 0;
- p2s_rstn 0;
- wr_en 0;
- wr_addr 0;
- wr_data 0;
- addr_err 0;
- busy 0.
REQ-030 Reset mid-frame SHALL discard the frame; the first posedge after release with csn=0 SHALL start a new command.

Structure
REQ-031 A shared package psec5_spi_pkg SHALL hold the state enum, NUM_REGS_DEFAULT=59, RESERVED_ADDR=0 and WRITE_FLAG_BIT=7.
REQ-032 SHALL instantiate one sub-module, s2p_shift_register (8-bit LSB-first shifter with bit counter and byte_done flag); the FSM and decode reside in spi_cmd_receiver.

Verification
REQ-033 Write: csn=0, bits of 0x85 then 0xA5 LSB first -> wr_en one cycle, wr_addr=0x05, wr_data=0xA5, addr_err=0.
REQ-034 Read: command 0x3B -> mux_addr=59 on the 8th edge; p2s_rstn=1 for exactly 8 cycles; then state IDLE with csn=1.
REQ-035 Invalid: write command 0xBC (addr 60) with data 0xFF -> no wr_en, addr_err pulse. Read 0x40 (addr 64) -> mux_addr=0, addr_err pulse.
REQ-036 Abort: csn raised after 12 bits of a write -> IDLE, no wr_en, p2s_rstn=0, busy=0 next cycle.
REQ-037 Back-to-back: write 0x81/0x11 then read 0x01 with csn held low -> wr_en once; then mux_addr=1 and READ entered without an IDLE cycle.
REQ-038 Reset: rstn asserted during READ cycle 4 -> all outputs at reset values immediately, without waiting for sclk.
